// File: rtl/rv32m_pkg.sv
// Shared RV32M sequencer definitions.
// funct3 codes, FSM states and ALU op select.
package rv32m_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [2:0] ALU_OP_ADD_SUB = 3'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  function automatic logic is_div(
    input logic [2:0] f3
  );
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's complement.
// Used for operand magnitudes and result sign fix-up.
module muldiv_negate #(
  parameter int W = 64
) (
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  assign val_o = en_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/alu_muldiv_seq.sv
// Radix-2 RV32M multiply/divide sequencer.
// Borrows the shared ALU for one add/sub per cycle.
module alu_muldiv_seq
  import rv32m_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic            flush,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic            alu_own,
  output logic [XLEN-1:0] seq_alu_op1,
  output logic [XLEN-1:0] seq_alu_op2,
  output logic [2:0]      seq_alu_func,
  output logic            seq_sub_sra,
  input  logic [XLEN-1:0] alu_q,
  input  logic            alu_ltu
);

  state_e          state_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] hi_q, lo_q, opb_q;
  logic [XLEN-1:0] res_q;
  logic            neg_q, valid_q;
  logic [4:0]      cnt_q;

  logic            in_prep, in_run, in_fix;
  logic            div_op, rem_op, sgn_a, sgn_b;
  logic            sa, sb, neg_res;
  logic            div_zero, div_ovf, mul_zero;
  logic [XLEN-1:0] spec_res, fix_res;
  logic [2*XLEN-1:0] fix_in, neg_in, neg_out;
  logic            neg_en;
  logic [XLEN-1:0] mag_b;
  logic            m_add, m_c, d_take;
  logic [XLEN-1:0] m_sum;

  assign in_prep = (state_q == S_PREP);
  assign in_run  = (state_q == S_RUN);
  assign in_fix  = (state_q == S_FIX);

  assign div_op = is_div(f3_q);
  assign rem_op = f3_q[1];
  assign sgn_a  = (f3_q == F3_MULH) || (f3_q == F3_MULHSU)
               || (f3_q == F3_DIV)  || (f3_q == F3_REM);
  assign sgn_b  = (f3_q == F3_MULH) || (f3_q == F3_DIV)
               || (f3_q == F3_REM);
  assign sa = sgn_a & a_q[XLEN-1];
  assign sb = sgn_b & b_q[XLEN-1];
  assign neg_res = (div_op && rem_op) ? sa : (sa ^ sb);

  assign fix_in = div_op
    ? {{XLEN{1'b0}}, (rem_op ? hi_q : lo_q)}
    : {hi_q, lo_q};
  assign neg_in = in_prep ? {{XLEN{1'b0}}, a_q} : fix_in;
  assign neg_en = in_prep ? sa : (in_fix & neg_q);

  muldiv_negate #(.W(2*XLEN)) u_neg_a (
    .en_i  (neg_en),
    .val_i (neg_in),
    .val_o (neg_out)
  );

  muldiv_negate #(.W(XLEN)) u_neg_b (
    .en_i  (sb),
    .val_i (b_q),
    .val_o (mag_b)
  );

  assign fix_res = (div_op || f3_q == F3_MUL)
    ? neg_out[XLEN-1:0]
    : neg_out[2*XLEN-1:XLEN];

  assign div_zero = div_op && (b_q == '0);
  assign div_ovf  = ((f3_q == F3_DIV) || (f3_q == F3_REM))
                 && (a_q == 32'h8000_0000)
                 && (b_q == 32'hFFFF_FFFF);
  assign mul_zero = FAST_ZERO && !div_op
                 && ((a_q == '0) || (b_q == '0));

  always_comb begin
    spec_res = '0;
    unique case (1'b1)
      div_zero: spec_res = rem_op ? a_q : '1;
      div_ovf:  spec_res = rem_op ? '0 : 32'h8000_0000;
      default:  spec_res = '0;
    endcase
  end

  // Divide shifts {rem,quo} left one bit before the trial subtract.
  assign seq_alu_op1 = !in_run ? '0
    : div_op ? {hi_q[XLEN-2:0], lo_q[XLEN-1]} : hi_q;
  assign seq_alu_op2  = in_run ? opb_q : '0;
  assign seq_sub_sra  = in_run & div_op;
  assign seq_alu_func = ALU_OP_ADD_SUB;
  assign alu_own      = in_run;

  assign m_add  = lo_q[0];
  assign m_sum  = m_add ? alu_q : hi_q;
  assign m_c    = m_add && (alu_q < hi_q);
  assign d_take = hi_q[XLEN-1] | ~alu_ltu;

  assign req_ready = (state_q == S_IDLE);
  assign res_valid = valid_q;
  assign res_data  = res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (flush && state_q != S_IDLE) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && !flush) begin
            f3_q    <= req_funct3;
            a_q     <= req_rs1;
            b_q     <= req_rs2;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          neg_q <= neg_res;
          cnt_q <= '0;
          hi_q  <= '0;
          if (div_op) begin
            lo_q  <= neg_out[XLEN-1:0];
            opb_q <= mag_b;
          end else begin
            lo_q  <= mag_b;
            opb_q <= neg_out[XLEN-1:0];
          end
          if (div_zero || div_ovf || mul_zero) begin
            res_q   <= spec_res;
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (div_op) begin
            hi_q <= d_take ? alu_q : seq_alu_op1;
            lo_q <= {lo_q[XLEN-2:0], d_take};
          end else begin
            hi_q <= {m_c, m_sum[XLEN-1:1]};
            lo_q <= {m_sum[0], lo_q[XLEN-1:1]};
          end
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= S_FIX;
        end
        S_FIX: begin
          res_q   <= fix_res;
          valid_q <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq.
// Shared ALU modelled here behind the alu_own mux.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_rs1 = 32'd0;
  logic [31:0] req_rs2 = 32'd0;
  logic        flush = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        alu_own;
  logic [31:0] seq_alu_op1, seq_alu_op2;
  logic [2:0]  seq_alu_func;
  logic        seq_sub_sra;
  logic [31:0] alu_q;
  logic        alu_ltu;

  logic [31:0] pipe_op1 = 32'h0000_1234;
  logic [31:0] pipe_op2 = 32'h0000_0011;
  logic [31:0] alu_a, alu_b;
  logic        alu_sub;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    alu_a   = alu_own ? seq_alu_op1 : pipe_op1;
    alu_b   = alu_own ? seq_alu_op2 : pipe_op2;
    alu_sub = alu_own ? seq_sub_sra : 1'b0;
    alu_q   = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
    alu_ltu = (alu_a < alu_b);
  end

  alu_muldiv_seq #(.XLEN(32), .FAST_ZERO(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .flush        (flush),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .alu_own      (alu_own),
    .seq_alu_op1  (seq_alu_op1),
    .seq_alu_op2  (seq_alu_op2),
    .seq_alu_func (seq_alu_func),
    .seq_sub_sra  (seq_sub_sra),
    .alu_q        (alu_q),
    .alu_ltu      (alu_ltu)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Leaves the DUT in DONE with the result on res_data.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] d,
                       output int lat, output int own);
    @(negedge clk);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_rs1    = a;
    req_rs2    = b;
    chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_funct3 = f3 ^ 3'd1;
    req_rs1    = ~a;
    req_rs2    = ~b;
    lat = 1;
    own = 0;
    while (!res_valid && lat < 100) begin
      if (alu_own) own++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    d = res_data;
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("ack_res_valid_low", {31'd0, res_valid}, 32'd0);
    chk("ack_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int lat, own, cnt;

    vecs[0]  = '{3'd0, 32'd7,         32'd6,         32'd42,        35};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  35};
    vecs[2]  = '{3'd1, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  35};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF,  35};
    vecs[4]  = '{3'd1, 32'h80000000,  32'h80000000,  32'h40000000,  35};
    vecs[5]  = '{3'd4, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  35};
    vecs[6]  = '{3'd6, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  35};
    vecs[7]  = '{3'd5, 32'd100,       32'd7,         32'd14,        35};
    vecs[8]  = '{3'd7, 32'd100,       32'd7,         32'd2,         35};
    vecs[9]  = '{3'd5, 32'd5,         32'd0,         32'hFFFFFFFF,  2};
    vecs[10] = '{3'd6, 32'd5,         32'd0,         32'd5,         2};
    vecs[11] = '{3'd4, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  2};
    vecs[12] = '{3'd6, 32'h80000000,  32'hFFFFFFFF,  32'd0,         2};
    vecs[13] = '{3'd0, 32'd0,         32'd5,         32'd0,         2};
    vecs[14] = '{3'd0, 32'hFFFFFFFD,  32'd5,         32'hFFFFFFF1,  35};
    vecs[15] = '{3'd4, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  35};
    vecs[16] = '{3'd6, 32'd7,         32'hFFFFFFFE,  32'd1,         35};
    vecs[17] = '{3'd2, 32'h80000000,  32'd2,         32'hFFFFFFFF,  35};

    #2;
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_alu_own", {31'd0, alu_own}, 32'd0);
    chk("rst_op1", seq_alu_op1, 32'd0);
    chk("rst_op2", seq_alu_op2, 32'd0);
    chk("rst_sub", {31'd0, seq_sub_sra}, 32'd0);
    chk("rst_func", {29'd0, seq_alu_func}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 18; i++) begin
      do_op(vecs[i].f3, vecs[i].a, vecs[i].b, d, lat, own);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_own_cycles", i), own,
          (vecs[i].lat == 35) ? 32 : 0);
      chk($sformatf("vec%0d_req_ready_done", i),
          {31'd0, req_ready}, 32'd0);
      ack();
    end

    // Result held under backpressure; no accept on the release cycle.
    do_op(3'd5, 32'd100, 32'd7, d, lat, own);
    req_valid  = 1'b1;
    req_funct3 = 3'd0;
    req_rs1    = 32'd3;
    req_rs2    = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_res_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_res_data", res_data, 32'd14);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    req_valid = 1'b0;
    chk("release_res_valid", {31'd0, res_valid}, 32'd0);
    chk("release_no_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("release_still_idle", {31'd0, req_ready}, 32'd1);

    // Flush at RUN cnt=10.
    @(negedge clk);
    req_valid  = 1'b1;
    req_funct3 = 3'd0;
    req_rs1    = 32'd7;
    req_rs2    = 32'd6;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("flush_run_started", {31'd0, alu_own}, 32'd1);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_alu_own", {31'd0, alu_own}, 32'd0);
    chk("flush_req_ready", {31'd0, req_ready}, 32'd1);
    chk("flush_op1_zero", seq_alu_op1, 32'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid) cnt++;
    end
    chk("flush_no_result", cnt, 0);

    // Flush in IDLE blocks a same-cycle request.
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    chk("idle_flush_no_accept", {31'd0, req_ready}, 32'd1);

    // Flush beats res_ready in DONE.
    do_op(3'd3, 32'h12345678, 32'h10, d, lat, own);
    chk("mulhu_small_data", d, 32'h1);
    flush     = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush     = 1'b0;
    res_ready = 1'b0;
    chk("done_flush_valid", {31'd0, res_valid}, 32'd0);
    chk("done_flush_ready", {31'd0, req_ready}, 32'd1);

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    req_valid  = 1'b1;
    req_funct3 = 3'd0;
    req_rs1    = 32'd7;
    req_rs2    = 32'd6;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("arst_in_run", {31'd0, alu_own}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_alu_own", {31'd0, alu_own}, 32'd0);
    chk("arst_op1", seq_alu_op1, 32'd0);
    chk("arst_op2", seq_alu_op2, 32'd0);
    chk("arst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("arst_res_data", res_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'd5, 32'd100, 32'd7, d, lat, own);
    chk("post_rst_data", d, 32'd14);
    chk("post_rst_latency", lat, 35);
    ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
